// File: rtl/gol_pkg.sv
// gol_pkg: shared definitions for the Game of Life sequencer.
//   BOARD_W     - board size in bits; cell (r,c) lives at bit r*8+c
//   gol_state_t - controller states
//   cell_idx    - maps a row/column pair to its board bit index
package gol_pkg;

  localparam int BOARD_W = 64;
  localparam int BOARD_N = 8;   // rows == columns

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } gol_state_t;

  function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c);
    return r * BOARD_N + c;
  endfunction

endpackage

// File: rtl/gol_sequencer_if.sv
// gol_sequencer_if: control, board and status signals between the
// switch/button top level (master) and the sequencer (slave).
//   load/seed_in          - reload the board and clear counters/flags
//   run/halt/step         - free-run, pause, single generation
//   max_gens/tick_period  - generation limit (0 = none), cycles per advance - 1
//   cur_board/next_board  - board to the datapath, its next generation back
//   gen_count, busy, done, extinct, still, period2 - status
interface gol_sequencer_if
  import gol_pkg::*;
#(
  parameter int GEN_W = 16,
  parameter int DIV_W = 24
);
  logic               load;
  logic [BOARD_W-1:0] seed_in;
  logic               run;
  logic               halt;
  logic               step;
  logic [GEN_W-1:0]   max_gens;
  logic [DIV_W-1:0]   tick_period;
  logic [BOARD_W-1:0] cur_board;
  logic [BOARD_W-1:0] next_board;
  logic [GEN_W-1:0]   gen_count;
  logic               busy;
  logic               done;
  logic               extinct;
  logic               still;
  logic               period2;

  modport master (
    output load, seed_in, run, halt, step, max_gens, tick_period, next_board,
    input  cur_board, gen_count, busy, done, extinct, still, period2
  );

  modport slave (
    input  load, seed_in, run, halt, step, max_gens, tick_period, next_board,
    output cur_board, gen_count, busy, done, extinct, still, period2
  );
endinterface

// File: rtl/gol_tick_div.sv
// gol_tick_div: advance-rate divider.
//   clk, reset   - clock, asynchronous active-low reset
//   i_clear      - synchronous clear back to 0 (takes priority over counting)
//   i_period     - tick fires while the count equals this value
//   o_tick       - count has reached i_period this cycle
module gol_tick_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_count <= '0;
    else if (i_clear) r_count <= '0;
    else              r_count <= r_count + DIV_W'(1);
  end

  assign o_tick = (r_count == i_period);
endmodule

// File: rtl/gol_sequencer.sv
// gol_sequencer: owns the 8x8 board register and sequences the external
// next-generation datapath: seed load, free-run at a programmable rate,
// pause, single step, generation limit, and extinction / still-life /
// period-2 detection.
//   clk, reset - clock, asynchronous active-low reset
//   bus        - gol_sequencer_if slave modport (controls in, board/status out)
module gol_sequencer
  import gol_pkg::*;
#(
  parameter int GEN_W = 16,
  parameter int DIV_W = 24
) (
  input logic              clk,
  input logic              reset,
  gol_sequencer_if.slave   bus
);
  gol_state_t         r_state, w_state_next;
  logic [BOARD_W-1:0] r_cur_board, r_prev_board;
  logic [GEN_W-1:0]   r_gen_count;
  logic               r_extinct, r_still, r_period2;

  logic               w_tick, w_div_clear, w_advance;
  logic               w_still_new, w_extinct_new, w_period2_new, w_limit_hit, w_terminal;
  logic [GEN_W-1:0]   w_gen_inc, w_gen_sat;

  // The divider only counts while genuinely free-running; every other
  // situation (including the advancing cycle itself) restarts it at 0.
  assign w_div_clear = (r_state != RUN) || bus.load || bus.halt || w_tick;

  gol_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_div_clear),
    .i_period (bus.tick_period),
    .o_tick   (w_tick)
  );

  assign w_still_new   = (bus.next_board == r_cur_board);
  assign w_extinct_new = (bus.next_board == '0);
  assign w_period2_new = (bus.next_board == r_prev_board) && !w_still_new;
  // Limit uses the wrapping increment, so a limit already passed only fires
  // again after the counter comes back around (or never, once saturated).
  assign w_gen_inc     = r_gen_count + GEN_W'(1);
  assign w_gen_sat     = (&r_gen_count) ? r_gen_count : w_gen_inc;
  assign w_limit_hit   = (bus.max_gens != '0) && (w_gen_inc == bus.max_gens);
  assign w_terminal    = w_still_new || w_extinct_new || w_limit_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    if (bus.load) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (bus.halt) begin
            w_state_next = r_state;
          end else if (bus.run) begin
            w_state_next = RUN;
          end else if (bus.step) begin
            w_advance = 1'b1;
          end
        end
        RUN: begin
          if (bus.halt)        w_state_next = PAUSE;
          else if (w_tick)     w_advance    = 1'b1;
        end
        DONE:    w_state_next = DONE;
        default: w_state_next = IDLE;
      endcase
      if (w_advance && w_terminal) w_state_next = DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_board  <= '0;
      r_prev_board <= '0;
      r_gen_count  <= '0;
      r_extinct    <= 1'b0;
      r_still      <= 1'b0;
      r_period2    <= 1'b0;
    end else if (bus.load) begin
      r_cur_board  <= bus.seed_in;
      r_prev_board <= '0;
      r_gen_count  <= '0;
      r_extinct    <= 1'b0;
      r_still      <= 1'b0;
      r_period2    <= 1'b0;
    end else if (w_advance) begin
      r_prev_board <= r_cur_board;
      r_cur_board  <= bus.next_board;
      r_gen_count  <= w_gen_sat;
      r_extinct    <= w_extinct_new;
      r_still      <= w_still_new;
      r_period2    <= w_period2_new;
    end
  end

  assign bus.cur_board = r_cur_board;
  assign bus.gen_count = r_gen_count;
  assign bus.busy      = (r_state == RUN);
  assign bus.done      = (r_state == DONE);
  assign bus.extinct   = r_extinct;
  assign bus.still     = r_still;
  assign bus.period2   = r_period2;
endmodule
